// File: rtl/uart_tx_device.sv
// Serial frame transmitter: start bit (0), DATA_W data bits LSB first, stop bit (1),
// each bit held for CLKS_PER_BIT clocks. All outputs are registered.
module uart_tx_device #(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 5
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              tx_start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_out,
   output logic              tx_busy,
   output logic              tx_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]        state;
   logic [CW-1:0]     clk_cnt;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shift;
   logic [DATA_W-1:0] shift_nxt;
   logic              bit_end;

   assign bit_end   = (clk_cnt == CLK_LAST);
   assign shift_nxt = shift >> 1;

   // rstn is active-high: a 1 at the edge forces idle and aborts any frame.
   always_ff @(posedge clk) begin
      if (rstn) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         tx_out  <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_start) begin
                  shift   <= tx_data;
                  clk_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= START;
                  tx_out  <= 1'b0;
                  tx_busy <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= DATA;
                  tx_out  <= shift[0];
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  shift   <= shift_nxt;
                  // Output is registered, so the next line value comes from the post-shift word.
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     state   <= STOP;
                     tx_out  <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx_out  <= shift_nxt[0];
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  state   <= IDLE;
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_device.sv
// Bench for uart_tx_device: frame-position reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_uart_tx_device;

   localparam int W = 4;
   localparam int C = 5;
   localparam int F = (W + 2) * C;
   localparam int MID = C / 2;

   logic         clk = 1'b0;
   logic         rstn = 1'b1;
   logic         tx_start = 1'b0;
   logic [W-1:0] tx_data = '0;
   logic         tx_out, tx_busy, tx_done;

   logic         start6 = 1'b0;
   logic [7:0]   data6 = 8'hA5;
   logic         out6, busy6, done6;

   always #5 clk = ~clk;

   uart_tx_device #(.DATA_W(W), .CLKS_PER_BIT(C)) dut (
      .clk(clk), .rstn(rstn), .tx_start(tx_start), .tx_data(tx_data),
      .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done));

   uart_tx_device #(.DATA_W(8), .CLKS_PER_BIT(1)) dut6 (
      .clk(clk), .rstn(rstn), .tx_start(start6), .tx_data(data6),
      .tx_out(out6), .tx_busy(busy6), .tx_done(done6));

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: position within the frame since acceptance, and the accepted word.
   bit           m_act = 1'b0;
   bit           m_done = 1'b0;
   int           m_pos = 0;
   logic [W-1:0] m_word = '0;

   always @(posedge clk) begin
      if (rstn) begin
         m_act  = 1'b0;
         m_done = 1'b0;
      end else if (m_act) begin
         m_done = 1'b0;
         m_pos++;
         if (m_pos == F) begin
            m_act  = 1'b0;
            m_done = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (tx_start) begin
            m_act  = 1'b1;
            m_pos  = 0;
            m_word = tx_data;
         end
      end
   end

   function automatic logic exp_out();
      int b;
      if (!m_act) return 1'b1;
      b = m_pos / C;
      if (b == 0) return 1'b0;
      if (b <= W) return m_word[b-1];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model tx_out", tx_out, exp_out());
         chk("model tx_busy", tx_busy, m_act);
         chk("model tx_done", tx_done, m_done);
      end
   end

   task automatic cyc(input logic r, input logic s, input logic [W-1:0] d);
      rstn = r;
      tx_start = s;
      tx_data = d;
      @(negedge clk);
   endtask

   // Optionally accepts w, then watches 31 cycles sampling each bit mid-way;
   // pulses tx_start with s_d at frame cycle s_at (-1 for none).
   task automatic frame(input bit acc, input logic [W-1:0] w, input int s_at,
                        input logic [W-1:0] s_d, output logic [W-1:0] rx,
                        output logic sb, output logic pb, output int nd, output int nb);
      int seg;
      rx = '0; sb = 1'bx; pb = 1'bx; nd = 0; nb = 0;
      if (acc) cyc(1'b0, 1'b1, w);
      for (int i = 0; i <= F; i++) begin
         seg = i / C;
         if (i % C == MID) begin
            if (seg == 0) sb = tx_out;
            else if (seg <= W) rx[seg-1] = tx_out;
            else pb = tx_out;
         end
         nd += int'(tx_done);
         nb += int'(tx_busy);
         cyc(1'b0, i == s_at, (i == s_at) ? s_d : '0);
      end
   endtask

   initial begin
      logic [5:0]   pat1;
      logic [9:0]   pat6;
      logic [W-1:0] rx;
      logic         sb, pb;
      int           nd, nb, mism, k;
      logic [W-1:0] words [4];

      cyc(1'b1, 1'b0, '0);
      chk_en = 1'b1;
      chk("reset tx_out", tx_out, 1'b1);
      chk("reset tx_busy", tx_busy, 1'b0);
      chk("reset tx_done", tx_done, 1'b0);
      cyc(1'b0, 1'b0, '0);

      // 1: 1010 -> segments 0,0,1,0,1,1 (start, LSB-first data, stop)
      pat1 = 6'b110100;
      mism = 0; nb = 0; nd = 0;
      cyc(1'b0, 1'b1, 4'b1010);
      for (int i = 0; i < F; i++) begin
         if (tx_out !== pat1[i/C]) mism++;
         nb += int'(tx_busy);
         nd += int'(tx_done);
         cyc(1'b0, 1'b0, '0);
      end
      chk("t1 line mismatches", mism, 0);
      chk("t1 busy cycles", nb, 30);
      chk("t1 early done", nd, 0);
      chk("t1 done at +31", tx_done, 1'b1);
      chk("t1 busy at +31", tx_busy, 1'b0);
      cyc(1'b0, 1'b0, '0);

      // 2: start during frame is ignored
      frame(1'b1, 4'b0110, 10, 4'b1111, rx, sb, pb, nd, nb);
      chk("t2 data", rx, 4'b0110);
      chk("t2 done pulses", nd, 1);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, '0);
      chk("t2 idle high", tx_out, 1'b1);
      chk("t2 idle busy", tx_busy, 1'b0);

      // 3: accept in the done cycle
      frame(1'b1, 4'b1000, F, 4'b0001, rx, sb, pb, nd, nb);
      chk("t3 frame1 data", rx, 4'b1000);
      chk("t3 frame1 stop", pb, 1'b1);
      chk("t3 frame1 done", nd, 1);
      chk("t3 frame2 start bit", tx_out, 1'b0);
      chk("t3 frame2 busy", tx_busy, 1'b1);
      frame(1'b0, '0, -1, '0, rx, sb, pb, nd, nb);
      chk("t3 frame2 data", rx, 4'b0001);
      chk("t3 frame2 done", nd, 1);

      // 4: reset during second data bit
      cyc(1'b0, 1'b1, 4'b0101);
      for (int i = 0; i < 11; i++) cyc(1'b0, 1'b0, '0);
      chk("t4 in data bit1", tx_out, 1'b0);
      cyc(1'b1, 1'b0, '0);
      chk("t4 abort tx_out", tx_out, 1'b1);
      chk("t4 abort busy", tx_busy, 1'b0);
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         nd += int'(tx_done);
         cyc(1'b0, 1'b0, '0);
      end
      chk("t4 no done", nd, 0);
      frame(1'b1, 4'b0101, -1, '0, rx, sb, pb, nd, nb);
      chk("t4 refire data", rx, 4'b0101);
      chk("t4 refire done", nd, 1);

      // 5: mid-bit receiver reconstruction
      words[0] = 4'h0; words[1] = 4'hF; words[2] = 4'h5; words[3] = 4'hA;
      foreach (words[j]) begin
         frame(1'b1, words[j], -1, '0, rx, sb, pb, nd, nb);
         chk("t5 rx word", rx, words[j]);
         chk("t5 start bit", sb, 1'b0);
         chk("t5 frame_err", pb !== 1'b1, 1'b0);
      end

      // 5b: wait bound on done
      cyc(1'b0, 1'b1, 4'h3);
      k = 0;
      while (tx_done !== 1'b1 && k < 40) begin
         cyc(1'b0, 1'b0, '0);
         k++;
      end
      chk("t5b done latency", k, F);

      // random: sparse starts, then held-high starts, rare resets
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 199) == 0,
             (i >= 300) ? 1'b1 : ($urandom_range(0, 7) == 0),
             W'($urandom));
      end
      cyc(1'b1, 1'b0, '0);

      // 6: DATA_W=8, CLKS_PER_BIT=1
      pat6 = 10'b1101001010;
      mism = 0; nb = 0; nd = 0;
      cyc(1'b0, 1'b0, '0);
      chk("t6 idle", out6, 1'b1);
      start6 = 1'b1;
      cyc(1'b0, 1'b0, '0);
      start6 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out6 !== pat6[i]) mism++;
         nb += int'(busy6);
         nd += int'(done6);
         cyc(1'b0, 1'b0, '0);
      end
      chk("t6 line mismatches", mism, 0);
      chk("t6 busy cycles", nb, 10);
      chk("t6 early done", nd, 0);
      chk("t6 done at +11", done6, 1'b1);
      cyc(1'b0, 1'b0, '0);
      chk("t6 done one cycle", done6, 1'b0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
